// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port arbitration bus: core writeback, debug host,
// clear control and the resulting register-file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_rd_address;
  logic [DATA_WIDTH-1:0] core_rd_data;

  logic                  dbg_valid;
  logic                  dbg_ready;
  logic [ADDR_WIDTH-1:0] dbg_address;
  logic [DATA_WIDTH-1:0] dbg_data;

  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;

  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_rd_address;
  logic [DATA_WIDTH-1:0] rf_rd_data;

  modport master (
    output core_we, core_rd_address, core_rd_data,
    output dbg_valid, dbg_address, dbg_data,
    output clear_start,
    input  dbg_ready, clear_busy, clear_done,
    input  rf_write_enable, rf_rd_address, rf_rd_data
  );

  modport slave (
    input  core_we, core_rd_address, core_rd_data,
    input  dbg_valid, dbg_address, dbg_data,
    input  clear_start,
    output dbg_ready, clear_busy, clear_done,
    output rf_write_enable, rf_rd_address, rf_rd_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Fixed-priority arbiter for the single register-file write port:
// core writeback > clear sequencer > debug host, one registered write per cycle.
//
// state | meaning
// IDLE  | no clear running; debug host may be granted
// CLEAR | zeroing x1..x(last), one register per cycle not taken by the core
// DONE  | clear finished; clear_done pulses, back to IDLE
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  ptr_load;
  logic                  ptr_advance;

  logic                  dbg_ready_int;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] grant_address;
  logic [DATA_WIDTH-1:0] grant_data;

  logic                  rf_write_enable_q;
  logic [ADDR_WIDTH-1:0] rf_rd_address_q;
  logic [DATA_WIDTH-1:0] rf_rd_data_q;
  logic                  clear_done_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      if (ptr_load) begin
        ptr <= FIRST_REG;
      end else if (ptr_advance) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // A core write steals the slot, so the pointer only moves on free cycles.
  always_comb begin
    next_state  = state;
    ptr_load    = 1'b0;
    ptr_advance = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_start) begin
          next_state = CLEAR;
          ptr_load   = 1'b1;
        end
      end
      CLEAR: begin
        if (!bus.core_we) begin
          if (ptr == LAST_REG) begin
            next_state = DONE;
          end else begin
            ptr_advance = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dbg_ready_int = reset && !bus.core_we && (state == IDLE);
    grant         = 1'b0;
    grant_address = '0;
    grant_data    = '0;
    if (bus.core_we) begin
      grant         = 1'b1;
      grant_address = bus.core_rd_address;
      grant_data    = bus.core_rd_data;
    end else if (state == CLEAR) begin
      grant         = 1'b1;
      grant_address = ptr;
      grant_data    = '0;
    end else if (bus.dbg_valid && dbg_ready_int) begin
      grant         = 1'b1;
      grant_address = bus.dbg_address;
      grant_data    = bus.dbg_data;
    end
  end

  // x0 is hardwired zero: the slot is consumed but no write is issued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_write_enable_q <= 1'b0;
      rf_rd_address_q   <= '0;
      rf_rd_data_q      <= '0;
      clear_done_q      <= 1'b0;
    end else begin
      rf_write_enable_q <= grant && (grant_address != '0);
      if (grant) begin
        rf_rd_address_q <= grant_address;
        rf_rd_data_q    <= grant_data;
      end
      clear_done_q <= (state == CLEAR) && (next_state == DONE);
    end
  end

  assign bus.dbg_ready       = dbg_ready_int;
  assign bus.clear_busy      = (state == CLEAR);
  assign bus.clear_done      = clear_done_q;
  assign bus.rf_write_enable = rf_write_enable_q;
  assign bus.rf_rd_address   = rf_rd_address_q;
  assign bus.rf_rd_data      = rf_rd_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the write port and register file.
module tb_regfile_write_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // register file driven by the DUT, and the model's view of it
  logic [DW-1:0] rf_mem [NREG] = '{default: '0};
  logic [DW-1:0] m_mem  [NREG] = '{default: '0};

  always @(posedge clock)
    if (bus.rf_write_enable === 1'b1) rf_mem[bus.rf_rd_address] <= bus.rf_rd_data;

  int cyc = 0;
  int done_cyc = -1;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (bus.clear_done === 1'b1) done_cyc = cyc;

  // model: clear progress and outputs expected in the next cycle
  bit          armed = 1'b0;
  bit          m_clearing = 1'b0;
  bit          m_done_now = 1'b0;
  int          m_next = 0;
  bit          e_we = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // called just after a falling edge; returns just after the next falling edge
  task automatic run_cycle(input bit rst, input bit cwe, input logic [AW-1:0] ca,
                           input logic [DW-1:0] cd, input bit dv, input logic [AW-1:0] da,
                           input logic [DW-1:0] dd, input bit cs, output bit xfer);
    bit            exp_ready, g, nd;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    reset               = rst;
    bus.core_we         = cwe;
    bus.core_rd_address = ca;
    bus.core_rd_data    = cd;
    bus.dbg_valid       = dv;
    bus.dbg_address     = da;
    bus.dbg_data        = dd;
    bus.clear_start     = cs;
    #1;
    if (armed) begin
      check_eq("clear_busy", 64'(bus.clear_busy), 64'(e_busy));
      check_eq("clear_done", 64'(bus.clear_done), 64'(e_done));
      check_eq("rf_we", 64'(bus.rf_write_enable), 64'(e_we));
      if (e_we) begin
        check_eq("rf_addr", 64'(bus.rf_rd_address), 64'(e_addr));
        check_eq("rf_data", 64'(bus.rf_rd_data), 64'(e_data));
      end
      if (e_we) m_mem[e_addr] = e_data;
    end
    exp_ready = rst && !cwe && !m_clearing && !m_done_now;
    check_eq("dbg_ready", 64'(bus.dbg_ready), 64'(exp_ready));
    xfer = dv && exp_ready;
    if (!rst) begin
      e_we = 0; e_addr = '0; e_data = '0; e_done = 0; e_busy = 0;
      m_clearing = 0; m_done_now = 0; m_next = 0;
      armed = 1'b1;
    end else begin
      g = 0; ga = '0; gd = '0;
      if (cwe) begin
        g = 1; ga = ca; gd = cd;
      end else if (m_clearing) begin
        g = 1; ga = AW'(m_next); gd = '0;
      end else if (xfer) begin
        g = 1; ga = da; gd = dd;
      end
      e_we = g && (ga != 0);
      if (g) begin e_addr = ga; e_data = gd; end
      nd = 0;
      if (m_clearing && !cwe) begin
        if (m_next == NREG - 1) begin m_clearing = 0; nd = 1; end
        else m_next++;
      end else if (!m_clearing && !m_done_now && cs) begin
        m_clearing = 1; m_next = 1;
      end
      m_done_now = nd;
      e_done = nd;
      e_busy = m_clearing;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    bit x;
    for (int i = 0; i < n; i++) run_cycle(1, 0, '0, '0, 0, '0, '0, 0, x);
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 1; i < NREG; i++) check_eq(tag, 64'(rf_mem[i]), 64'(m_mem[i]));
  endtask

  task automatic preload_all();
    bit x;
    for (int i = 1; i < NREG; i++)
      run_cycle(1, 0, '0, '0, 1, AW'(i), ($urandom | 32'h1), 0, x);
  endtask

  initial begin
    bit x, pend;
    int start_cyc, nonzero;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    reset = 1'b0;
    bus.core_we = 0; bus.core_rd_address = '0; bus.core_rd_data = '0;
    bus.dbg_valid = 0; bus.dbg_address = '0; bus.dbg_data = '0; bus.clear_start = 0;
    @(negedge clock);

    // reset held with competing requests
    run_cycle(0, 1, 5'd5, 32'hAAAA_5555, 1, 5'd6, 32'h1234, 0, x);
    run_cycle(0, 1, 5'd5, 32'hAAAA_5555, 1, 5'd6, 32'h1234, 0, x);
    check_eq("rst_rf_data", 64'(bus.rf_rd_data), 64'h0);
    check_eq("rst_rf_addr", 64'(bus.rf_rd_address), 64'h0);
    run_cycle(1, 0, '0, '0, 0, '0, '0, 0, x);

    // core beats debug, debug follows
    run_cycle(1, 1, 5'd5, 32'hAAAA_5555, 1, 5'd6, 32'h1234, 0, x);
    run_cycle(1, 0, '0, '0, 1, 5'd6, 32'h1234, 0, x);
    check_eq("dbg_x6_xfer", 64'(x), 64'h1);
    idle_cycles(1);
    check_eq("x6_committed", 64'(rf_mem[6]), 64'h1234);

    // debug write to x0 completes but never reaches the register file
    run_cycle(1, 0, '0, '0, 1, 5'd0, 32'hFFFF_FFFF, 0, x);
    idle_cycles(2);

    // full uncontested clear
    preload_all();
    idle_cycles(1);
    done_cyc = -1;
    start_cyc = cyc;
    run_cycle(1, 0, '0, '0, 0, '0, '0, 1, x);
    for (int k = 0; k < 34; k++) run_cycle(1, 0, '0, '0, 1, 5'd7, 32'h77, 0, x);
    check_eq("clr_latency", 64'(done_cyc - start_cyc), 64'd32);
    compare_mem("clr_mem");
    nonzero = 0;
    for (int i = 1; i < NREG; i++) if (rf_mem[i] != 0 && i != 7) nonzero++;
    check_eq("clr_all_zero", 64'(nonzero), 64'd0);

    // clear stalled by three core writes and a redundant start pulse
    preload_all();
    idle_cycles(1);
    done_cyc = -1;
    start_cyc = cyc;
    run_cycle(1, 0, '0, '0, 0, '0, '0, 1, x);
    for (int k = 1; k <= 38; k++) begin
      if (k == 5 || k == 12 || k == 20)
        run_cycle(1, 1, AW'(k + 3), 32'hC0DE_0000 + k, 0, '0, '0, 0, x);
      else
        run_cycle(1, 0, '0, '0, 0, '0, '0, (k == 8), x);
    end
    check_eq("stall_latency", 64'(done_cyc - start_cyc), 64'd35);
    compare_mem("stall_mem");

    // reset while the clear pointer sits at x10
    preload_all();
    idle_cycles(1);
    done_cyc = -1;
    run_cycle(1, 0, '0, '0, 0, '0, '0, 1, x);
    idle_cycles(9);
    run_cycle(0, 0, '0, '0, 0, '0, '0, 0, x);
    idle_cycles(40);
    check_eq("abort_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("abort_x9_zero", 64'(rf_mem[9]), 64'h0);
    check_eq("abort_x11_kept", 64'(rf_mem[11] != 0), 64'h1);
    compare_mem("abort_mem");

    // random traffic
    pend = 0; pa = '0; pd = '0;
    for (int n = 0; n < 3000; n++) begin
      bit rst, cwe, cs;
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        pa = AW'($urandom_range(0, NREG - 1));
        pd = $urandom;
      end
      rst = ($urandom_range(0, 199) != 0);
      cwe = ($urandom_range(0, 9) < 3);
      cs  = ($urandom_range(0, 49) == 0);
      run_cycle(rst, cwe, AW'($urandom_range(0, NREG - 1)), $urandom, pend, pa, pd, cs, x);
      if (x || !rst) pend = 0;
    end
    idle_cycles(40);
    compare_mem("rand_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
